// File: rtl/store_queue.sv
// In-order store buffer: holds issued stores until commit, snoops AGU/CDB,
// drains to data memory and answers one load forwarding query per cycle.
module store_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int N_CDB  = 2,
  parameter int FWD_EN = 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int SW    = (N_CDB > 1) ? $clog2(N_CDB) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic                    enq_addr_valid,
  input  logic [ADDR_W-1:0]       enq_addr,
  input  logic                    enq_data_valid,
  input  logic [TAG_W-1:0]        enq_data_tag,
  input  logic [SW-1:0]           enq_src,
  input  logic [DATA_W-1:0]       enq_data,
  input  logic                    agu_valid,
  input  logic [PW-1:0]           agu_idx,
  input  logic [ADDR_W-1:0]       agu_addr,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [N_CDB*DATA_W-1:0] cdb_data,
  input  logic                    commit_valid,
  output logic                    commit_ready,
  input  logic                    flush,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [PW:0]             ld_older,
  output logic                    ld_hit,
  output logic [DATA_W-1:0]       ld_data,
  output logic                    ld_stall,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [PW:0]             count
);

  typedef struct packed {
    logic              v;
    logic              av;
    logic              dv;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [SW-1:0]     src;
  } ent_t;

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  ent_t              q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       cnt;

  logic              commit_fire;
  logic              enq_fire;
  logic [PW-1:0]     agu_ptr;
  logic              agu_ok;
  logic [DEPTH-1:0]  cap;
  logic [DATA_W-1:0] cap_data [DEPTH];
  logic              enq_cap;
  logic [DATA_W-1:0] enq_cap_data;
  ent_t              new_ent;

  logic [PW-1:0]     p;
  logic              any_pend;
  logic              m_found;
  logic              m_dv;
  logic [DATA_W-1:0] m_data;

  assign count        = cnt;
  assign commit_ready = q[head].v & q[head].av & q[head].dv;
  assign commit_fire  = commit_valid & commit_ready;
  assign enq_ready    = (cnt < FULL) | commit_fire;
  assign enq_fire     = enq_valid & enq_ready & ~flush;
  assign agu_ptr      = head + agu_idx;
  assign agu_ok       = agu_valid
                      & ({1'b0, agu_idx} < cnt)
                      & ~q[agu_ptr].av;

  // each entry listens only to the bus that produces its data
  always_comb begin
    cap          = '0;
    enq_cap      = 1'b0;
    enq_cap_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cap_data[i] = '0;
      for (int b = 0; b < N_CDB; b++) begin
        if (cdb_valid[b]
            && q[i].src == SW'(b)
            && cdb_tag[b*TAG_W +: TAG_W] == q[i].tag) begin
          cap[i]      = 1'b1;
          cap_data[i] = cdb_data[b*DATA_W +: DATA_W];
        end
      end
    end
    for (int b = 0; b < N_CDB; b++) begin
      if (cdb_valid[b]
          && enq_src == SW'(b)
          && cdb_tag[b*TAG_W +: TAG_W] == enq_data_tag) begin
        enq_cap      = 1'b1;
        enq_cap_data = cdb_data[b*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    new_ent      = '0;
    new_ent.v    = 1'b1;
    new_ent.av   = enq_addr_valid;
    new_ent.addr = enq_addr;
    new_ent.tag  = enq_data_tag;
    new_ent.src  = enq_src;
    new_ent.dv   = enq_data_valid | enq_cap;
    new_ent.data = enq_data_valid ? enq_data
                                  : enq_cap_data;
  end

  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    ld_stall = 1'b0;
    any_pend = 1'b0;
    m_found  = 1'b0;
    m_dv     = 1'b0;
    m_data   = '0;
    p        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = head + PW'(i);
      if (i < int'(ld_older) && q[p].v) begin
        if (!q[p].av) begin
          any_pend = 1'b1;
        end else if (q[p].addr == ld_addr) begin
          m_found = 1'b1;
          m_dv    = q[p].dv;
          m_data  = q[p].data;
        end
      end
    end
    if (ld_valid) begin
      if (any_pend) begin
        ld_stall = 1'b1;
      end else if (m_found) begin
        if (FWD_EN != 0 && m_dv) begin
          ld_hit  = 1'b1;
          ld_data = m_data;
        end else begin
          ld_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      mem_we <= commit_fire;
      if (commit_fire) begin
        mem_addr  <= q[head].addr;
        mem_wdata <= q[head].data;
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          q[i].v  <= 1'b0;
          q[i].av <= 1'b0;
          q[i].dv <= 1'b0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q[i].v && !q[i].dv && cap[i]) begin
            q[i].dv   <= 1'b1;
            q[i].data <= cap_data[i];
          end
        end
        if (agu_ok) begin
          q[agu_ptr].av   <= 1'b1;
          q[agu_ptr].addr <= agu_addr;
        end
        if (commit_fire) begin
          q[head].v <= 1'b0;
          head      <= head + PW'(1);
        end
        // full + commit: tail aliases head, new entry overrides
        if (enq_fire) begin
          q[tail] <= new_ent;
          tail    <= tail + PW'(1);
        end
        cnt <= cnt + (PW+1)'(enq_fire)
                   - (PW+1)'(commit_fire);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (agu_valid) begin
        assert (({1'b0, agu_idx} < cnt)
                && !q[agu_ptr].av)
          else $error("store_queue: illegal agu write");
      end
      if (commit_valid) begin
        assert (commit_ready)
          else $error("store_queue: commit not ready");
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Randomised and directed bench for store_queue against a queue-based model;
// two instances cover forwarding enabled and disabled.
module tb_store_queue;
  localparam int DEPTH = 8;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int NC = 2;

  logic clk = 0;
  logic reset_n = 0;
  logic enq_valid, enq_addr_valid, enq_data_valid;
  logic [AW-1:0] enq_addr, agu_addr, ld_addr;
  logic [TW-1:0] enq_data_tag;
  logic [0:0] enq_src;
  logic [DW-1:0] enq_data;
  logic agu_valid;
  logic [2:0] agu_idx;
  logic [NC-1:0] cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_data;
  logic commit_valid, flush, ld_valid;
  logic [3:0] ld_older;

  logic er_f, cr_f, hit_f, stall_f, we_f;
  logic [DW-1:0] ldd_f, wd_f;
  logic [AW-1:0] wa_f;
  logic [3:0] cnt_f;
  logic er_n, cr_n, hit_n, stall_n, we_n;
  logic [DW-1:0] ldd_n, wd_n;
  logic [AW-1:0] wa_n;
  logic [3:0] cnt_n;

  always #5 clk = ~clk;

  store_queue #(.FWD_EN(1)) u_fwd (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(er_f),
    .enq_addr_valid(enq_addr_valid), .enq_addr(enq_addr),
    .enq_data_valid(enq_data_valid), .enq_data_tag(enq_data_tag),
    .enq_src(enq_src), .enq_data(enq_data),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(cr_f), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_older(ld_older),
    .ld_hit(hit_f), .ld_data(ldd_f), .ld_stall(stall_f),
    .mem_we(we_f), .mem_addr(wa_f), .mem_wdata(wd_f), .count(cnt_f)
  );

  store_queue #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(er_n),
    .enq_addr_valid(enq_addr_valid), .enq_addr(enq_addr),
    .enq_data_valid(enq_data_valid), .enq_data_tag(enq_data_tag),
    .enq_src(enq_src), .enq_data(enq_data),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(cr_n), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_older(ld_older),
    .ld_hit(hit_n), .ld_data(ldd_n), .ld_stall(stall_n),
    .mem_we(we_n), .mem_addr(wa_n), .mem_wdata(wd_n), .count(cnt_n)
  );

  typedef struct {
    bit av;
    logic [AW-1:0] addr;
    bit dv;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int src;
  } m_t;

  m_t mq[$];
  bit exp_we;
  logic [AW-1:0] exp_wa;
  logic [DW-1:0] exp_wd;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit head_ready();
    return mq.size() > 0 && mq[0].av && mq[0].dv;
  endfunction

  function automatic void exp_load(input bit fwd, output bit hit,
                                   output logic [DW-1:0] d,
                                   output bit stall);
    int n;
    hit = 0; d = '0; stall = 0;
    if (!ld_valid) return;
    n = (int'(ld_older) < mq.size()) ? int'(ld_older) : mq.size();
    for (int i = 0; i < n; i++)
      if (!mq[i].av) stall = 1;
    if (stall) return;
    for (int i = n - 1; i >= 0; i--) begin
      if (mq[i].addr == ld_addr) begin
        if (fwd && mq[i].dv) begin
          hit = 1;
          d = mq[i].data;
        end else begin
          stall = 1;
        end
        return;
      end
    end
  endfunction

  function automatic bit bus_hit(input int b, input logic [TW-1:0] t);
    return cdb_valid[b] && cdb_tag[b*TW +: TW] == t;
  endfunction

  task automatic sample();
    bit h, s;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("count", cnt_f, mq.size());
    chk("count_nofwd", cnt_n, mq.size());
    chk("enq_ready", er_f,
        mq.size() < DEPTH || (commit_valid && head_ready()));
    chk("commit_ready", cr_f, head_ready());
    exp_load(1, h, d, s);
    chk("ld_hit", hit_f, h);
    chk("ld_stall", stall_f, s);
    if (h) chk("ld_data", ldd_f, d);
    exp_load(0, h, d, s);
    chk("ld_hit_nofwd", hit_n, h);
    chk("ld_stall_nofwd", stall_n, s);
    chk("mem_we", we_f, exp_we);
    if (exp_we) begin
      chk("mem_addr", wa_f, exp_wa);
      chk("mem_wdata", wd_f, exp_wd);
    end
  endtask

  task automatic tick();
    bit cf, ef;
    m_t e;
    @(posedge clk);
    cf = commit_valid && head_ready();
    ef = enq_valid && (mq.size() < DEPTH || cf);
    exp_we = cf;
    if (cf) begin
      exp_wa = mq[0].addr;
      exp_wd = mq[0].data;
    end
    if (flush) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        e = mq[i];
        if (!e.dv && bus_hit(e.src, e.tag)) begin
          e.dv = 1;
          e.data = cdb_data[e.src*DW +: DW];
          mq[i] = e;
        end
      end
      if (agu_valid) begin
        e = mq[agu_idx];
        e.av = 1;
        e.addr = agu_addr;
        mq[agu_idx] = e;
      end
      if (cf) void'(mq.pop_front());
      if (ef) begin
        e.av = enq_addr_valid;
        e.addr = enq_addr;
        e.dv = enq_data_valid;
        e.data = enq_data;
        e.tag = enq_data_tag;
        e.src = int'(enq_src);
        if (!e.dv && bus_hit(e.src, e.tag)) begin
          e.dv = 1;
          e.data = cdb_data[e.src*DW +: DW];
        end
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    enq_valid = 0; enq_addr_valid = 0; enq_addr = '0;
    enq_data_valid = 0; enq_data_tag = '0; enq_src = '0;
    enq_data = '0; agu_valid = 0; agu_idx = '0; agu_addr = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    commit_valid = 0; flush = 0; ld_valid = 0;
    ld_addr = '0; ld_older = '0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit av, input bit dv,
                      input logic [TW-1:0] tg, input bit s);
    idle();
    enq_valid = 1; enq_addr = a; enq_data = d;
    enq_addr_valid = av; enq_data_valid = dv;
    enq_data_tag = tg; enq_src = s;
    sample();
    tick();
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    sample();
    tick();
    idle();
  endtask

  task automatic load(input logic [AW-1:0] a, input int older);
    idle();
    ld_valid = 1;
    ld_addr = a;
    ld_older = 4'(older);
  endtask

  initial begin
    int pend[$];
    idle();
    exp_we = 0; exp_wa = '0; exp_wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", cnt_f, 0);
    chk("rst_enq_ready", er_f, 1);
    chk("rst_commit_ready", cr_f, 0);
    chk("rst_mem_we", we_f, 0);
    reset_n = 1;
    @(posedge clk); #1;

    // reset mid-fill, with a write strobe pending
    push(17'h1, 32'h11, 1, 1, 0, 0);
    push(17'h2, 32'h22, 1, 1, 0, 0);
    push(17'h3, 32'h33, 1, 1, 0, 0);
    idle(); commit_valid = 1;
    sample(); tick();
    idle();
    chk("pre_rst_mem_we", we_f, 1);
    reset_n = 0;
    #1;
    chk("midrst_count", cnt_f, 0);
    chk("midrst_mem_we", we_f, 0);
    chk("midrst_enq_ready", er_f, 1);
    mq.delete(); exp_we = 0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // fill, full commit+enqueue, drain across wrap
    for (int i = 0; i < DEPTH; i++)
      push(17'h100 + 17'(i), 32'hA0 + i, 1, 1, 0, 0);
    idle();
    sample();
    chk("full_enq_ready", er_f, 0);
    chk("full_count", cnt_f, 8);
    tick();
    idle();
    commit_valid = 1; enq_valid = 1; enq_addr_valid = 1;
    enq_data_valid = 1; enq_addr = 17'h200; enq_data = 32'hB0;
    sample();
    chk("full_commit_enq_ready", er_f, 1);
    tick();
    idle();
    sample();
    chk("full_after_count", cnt_f, 8);
    chk("full_after_mem_addr", wa_f, 17'h100);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); commit_valid = 1;
      sample(); tick();
    end
    idle(); sample(); tick();

    // late data on bus 1 only
    push(17'h50, 32'h0, 1, 0, 6'd5, 1);
    idle();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5};
    cdb_data = {32'h0, 32'h12345678};
    sample(); tick();
    idle(); sample();
    chk("late_cdb0_ready", cr_f, 0);
    tick();
    idle();
    cdb_valid = 2'b10; cdb_tag = {6'd5, 6'd0};
    cdb_data = {32'hDEADBEEF, 32'h0};
    sample(); tick();
    idle(); sample();
    chk("late_cdb1_ready", cr_f, 1);
    tick();
    idle(); commit_valid = 1; sample(); tick();
    idle(); sample();
    chk("late_mem_wdata", wd_f, 32'hDEADBEEF);
    tick();

    // forwarding: youngest older match wins
    do_flush();
    push(17'h10, 32'd1, 1, 1, 0, 0);
    push(17'h10, 32'd2, 1, 1, 0, 0);
    push(17'h20, 32'd3, 1, 1, 0, 0);
    load(17'h10, 3);
    sample();
    chk("fwd3_hit", hit_f, 1);
    chk("fwd3_data", ldd_f, 2);
    chk("fwd3_nofwd_stall", stall_n, 1);
    tick();
    load(17'h10, 1);
    sample();
    chk("fwd1_data", ldd_f, 1);
    tick();
    load(17'h10, 0);
    sample();
    chk("fwd0_nofwd_stall", stall_n, 0);
    tick();

    // disambiguation: unresolved older address stalls
    do_flush();
    push(17'h60, 32'h66, 1, 1, 0, 0);
    push(17'h4, 32'h77, 0, 1, 0, 0);
    load(17'h30, 2);
    sample();
    chk("dis_stall", stall_f, 1);
    tick();
    load(17'h30, 2);
    agu_valid = 1; agu_idx = 3'd1; agu_addr = 17'h40;
    sample();
    chk("dis_same_cycle_stall", stall_f, 1);
    tick();
    load(17'h30, 2);
    sample();
    chk("dis_res_stall", stall_f, 0);
    chk("dis_res_hit", hit_f, 0);
    tick();

    // flush together with commit and enqueue
    push(17'h70, 32'h88, 1, 1, 0, 0);
    push(17'h71, 32'h99, 1, 1, 0, 0);
    idle();
    flush = 1; commit_valid = 1;
    enq_valid = 1; enq_addr_valid = 1; enq_data_valid = 1;
    enq_addr = 17'h7F; enq_data = 32'h7F;
    sample(); tick();
    idle(); sample();
    chk("flush_count", cnt_f, 0);
    chk("flush_mem_we", we_f, 1);
    chk("flush_mem_addr", wa_f, 17'h60);
    tick();
    idle(); sample();
    chk("flush_mem_we_next", we_f, 0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      enq_valid = ($urandom % 3) != 0;
      enq_addr_valid = ($urandom % 3) != 0;
      enq_addr = 17'($urandom % 8);
      enq_data_valid = ($urandom % 2) != 0;
      enq_data = $urandom;
      enq_data_tag = 6'($urandom % 8);
      enq_src = 1'($urandom % 2);
      pend.delete();
      foreach (mq[i]) if (!mq[i].av) pend.push_back(i);
      if (pend.size() > 0 && ($urandom % 2) != 0) begin
        agu_valid = 1;
        agu_idx = 3'(pend[$urandom_range(0, pend.size() - 1)]);
        agu_addr = 17'($urandom % 8);
      end
      for (int b = 0; b < NC; b++) begin
        cdb_valid[b] = ($urandom % 2) != 0;
        cdb_tag[b*TW +: TW] = 6'($urandom % 8);
        cdb_data[b*DW +: DW] = $urandom;
      end
      commit_valid = head_ready() && ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      ld_valid = ($urandom % 4) != 0;
      ld_addr = 17'($urandom % 8);
      ld_older = 4'($urandom_range(0, mq.size()));
      sample();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
